// File: rtl/dynamic_priority_arbiter_aging_pkg.sv
// Shared arbiter definitions: hold/idle state encoding and the saturating
// subtract used to turn a static priority plus an aging boost into an effective priority.
package arb_pkg;

  localparam int SAT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // a - b clamped at zero; callers zero-extend narrower fields into SAT_W bits
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/dynamic_priority_arbiter_aging_if.sv
// Request/grant bundle between requesting masters and the aging arbiter.
// The master side drives requests and priorities; the slave side (the arbiter) returns the grant.
interface dynamic_priority_arbiter_aging_if #(
  parameter int N  = 4,
  parameter int LN = $clog2(N),
  parameter int PW = 2
);
  logic              clk_en;
  logic [N-1:0]      req;
  logic [PW-1:0]     prt [N];
  logic              release_grant;
  logic [LN-1:0]     grant;
  logic [N-1:0]      grant_oh;
  logic              valid;

  modport master (
    output clk_en, req, prt, release_grant,
    input  grant, grant_oh, valid
  );

  modport slave (
    input  clk_en, req, prt, release_grant,
    output grant, grant_oh, valid
  );
endinterface

// File: rtl/dynamic_priority_arbiter_aging_age_counter.sv
// Per-requester aging: while a request waits ungranted, every AGE_TH cycles the
// priority boost steps up by one (saturating). AGE_TH = 0 keeps the boost at zero.
module arb_age_counter #(
  parameter int AGE_TH = 8,
  parameter int PW     = 2
) (
  input  logic          clk,
  input  logic          clk_en,
  input  logic          rst,
  input  logic          req,
  input  logic          granted,
  output logic [PW-1:0] boost
);

  localparam int            WW        = (AGE_TH > 1) ? $clog2(AGE_TH) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (AGE_TH > 0) ? WW'(AGE_TH - 1) : '0;
  localparam logic [PW-1:0] BOOST_MAX = '1;

  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      boost    <= '0;
    end else if (clk_en) begin
      if ((AGE_TH == 0) || !req || granted) begin
        wait_cnt <= '0;
        boost    <= '0;
      end else if (wait_cnt == WAIT_LAST) begin
        wait_cnt <= '0;
        if (boost != BOOST_MAX) boost <= boost + 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dynamic_priority_arbiter_aging.sv
// N-way registered arbiter: minimum effective priority wins, round-robin among ties,
// grant locked until release (or request drop), aging boosts keep waiters from starving.
module dynamic_priority_arbiter_aging
  import arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int LN     = $clog2(N),
  parameter int PW     = 2,
  parameter int AGE_TH = 8
) (
  input logic                          clk,
  input logic                          rst,
  dynamic_priority_arbiter_aging_if.slave bus
);

  arb_state_e    state_q, state_n;
  logic [LN-1:0] grant_q, grant_n;
  logic [LN-1:0] rr_ptr_q, rr_ptr_n;
  logic [N-1:0]  grant_oh_q, grant_oh_n;

  logic [PW-1:0] boost [N];
  logic [PW-1:0] eff   [N];
  logic [PW-1:0] min_eff;
  logic [N-1:0]  arb_req, cand, granted;
  logic [LN-1:0] win_idx;
  logic          any_win, found, load;

  for (genvar i = 0; i < N; i++) begin : g_age
    assign granted[i] = ((state_q == HOLD) && (grant_q == LN'(i))) ||
                        (load && (win_idx == LN'(i)));

    arb_age_counter #(
      .AGE_TH (AGE_TH),
      .PW     (PW)
    ) u_age (
      .clk     (clk),
      .clk_en  (bus.clk_en),
      .rst     (rst),
      .req     (bus.req[i]),
      .granted (granted[i]),
      .boost   (boost[i])
    );
  end

  // The current holder never competes in its own handoff; grant_oh_q is zero in IDLE.
  assign arb_req = bus.req & ~grant_oh_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff[i] = PW'(sat_sub(SAT_W'(bus.prt[i]), SAT_W'(boost[i])));
    end
  end

  always_comb begin
    min_eff = '1;
    for (int i = 0; i < N; i++) begin
      if (arb_req[i] && (eff[i] < min_eff)) min_eff = eff[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = arb_req[i] && (eff[i] == min_eff);
    end
  end

  // First candidate after the last winner, wrapping modulo N.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && cand[(int'(rr_ptr_q) + k) % N]) begin
        win_idx = LN'((int'(rr_ptr_q) + k) % N);
        found   = 1'b1;
      end
    end
    any_win = found;
  end

  always_comb begin
    state_n    = state_q;
    grant_n    = grant_q;
    grant_oh_n = grant_oh_q;
    rr_ptr_n   = rr_ptr_q;
    load       = 1'b0;
    if (bus.clk_en) begin
      case (state_q)
        IDLE: begin
          if (any_win) load = 1'b1;
        end
        HOLD: begin
          if (bus.release_grant || !bus.req[grant_q]) begin
            if (any_win) begin
              load = 1'b1;
            end else begin
              state_n    = IDLE;
              grant_oh_n = '0;
            end
          end
        end
        default: ;
      endcase
    end
    if (load) begin
      state_n    = HOLD;
      grant_n    = win_idx;
      grant_oh_n = N'(1) << win_idx;
      rr_ptr_n   = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= LN'(N - 1);
    end else begin
      state_q    <= state_n;
      grant_q    <= grant_n;
      grant_oh_q <= grant_oh_n;
      rr_ptr_q   <= rr_ptr_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_oh = grant_oh_q;
  assign bus.valid    = (state_q == HOLD);

endmodule

// File: tb/tb_dynamic_priority_arbiter_aging.sv
// Two arbiters (aging off and AGE_TH=4) driven with identical stimulus and
// compared each cycle against a behavioural model through per-instance scoreboards.
module tb_dynamic_priority_arbiter_aging;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dynamic_priority_arbiter_aging_if #(.N(N), .PW(2)) bus0 ();
  dynamic_priority_arbiter_aging_if #(.N(N), .PW(2)) bus1 ();

  dynamic_priority_arbiter_aging #(.N(N), .PW(2), .AGE_TH(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  dynamic_priority_arbiter_aging #(.N(N), .PW(2), .AGE_TH(4)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  typedef struct {
    bit         valid;
    int         grant;
    logic [3:0] oh;
    bit         chk_grant;
    int         cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_no = 0;

  // stimulus currently applied
  bit         t_rst, t_ce, t_rel;
  logic [3:0] t_req;
  int         t_prt [N];

  // reference model state per instance
  int age_th [2] = '{0, 4};
  bit m_valid [2];
  int m_grant [2];
  int m_rr    [2];
  int m_wait  [2][N];
  int m_boost [2][N];

  function automatic exp_t model_step(input int d);
    exp_t e;
    int   eff [N];
    int   win;
    bit   arb;
    if (t_rst) begin
      m_valid[d] = 0;
      m_grant[d] = 0;
      m_rr[d]    = N - 1;
      for (int i = 0; i < N; i++) begin
        m_wait[d][i]  = 0;
        m_boost[d][i] = 0;
      end
    end else if (t_ce) begin
      for (int i = 0; i < N; i++)
        eff[i] = (t_prt[i] > m_boost[d][i]) ? t_prt[i] - m_boost[d][i] : 0;
      arb = !m_valid[d] || t_rel || !t_req[m_grant[d]];
      win = -1;
      // most urgent level first, then round-robin order after the last winner
      if (arb) begin
        for (int lvl = 0; lvl < 4 && win < 0; lvl++) begin
          for (int k = 1; k <= N && win < 0; k++) begin
            int i = (m_rr[d] + k) % N;
            if (t_req[i] && !(m_valid[d] && i == m_grant[d]) && eff[i] == lvl) win = i;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (age_th[d] == 0 || !t_req[i] || (m_valid[d] && m_grant[d] == i) || win == i) begin
          m_wait[d][i]  = 0;
          m_boost[d][i] = 0;
        end else if (m_wait[d][i] == age_th[d] - 1) begin
          m_wait[d][i] = 0;
          if (m_boost[d][i] < 3) m_boost[d][i]++;
        end else begin
          m_wait[d][i]++;
        end
      end
      if (arb) begin
        if (win >= 0) begin
          m_valid[d] = 1;
          m_grant[d] = win;
          m_rr[d]    = win;
        end else begin
          m_valid[d] = 0;
        end
      end
    end
    e.valid     = m_valid[d];
    e.grant     = m_grant[d];
    e.oh        = m_valid[d] ? (4'b0001 << m_grant[d]) : 4'b0000;
    e.chk_grant = m_valid[d] || t_rst;
    e.cyc       = cyc_no;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit ce, input logic [3:0] rq, input bit rl);
    t_rst = r; t_ce = ce; t_req = rq; t_rel = rl;
    rst = r;
    bus0.clk_en = ce; bus1.clk_en = ce;
    bus0.req = rq;    bus1.req = rq;
    bus0.release_grant = rl; bus1.release_grant = rl;
    for (int i = 0; i < N; i++) begin
      bus0.prt[i] = 2'(t_prt[i]);
      bus1.prt[i] = 2'(t_prt[i]);
    end
    sb0.push_back(model_step(0));
    sb1.push_back(model_step(1));
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic set_prt(input int p3, input int p2, input int p1, input int p0);
    t_prt[3] = p3; t_prt[2] = p2; t_prt[1] = p1; t_prt[0] = p0;
  endtask

  task automatic check(input int d, input exp_t e);
    logic       av;
    logic [1:0] ag;
    logic [3:0] aoh;
    if (d == 0) begin
      av = bus0.valid; ag = bus0.grant; aoh = bus0.grant_oh;
    end else begin
      av = bus1.valid; ag = bus1.grant; aoh = bus1.grant_oh;
    end
    n_cmp++;
    if (av !== e.valid || aoh !== e.oh || (e.chk_grant && ag !== 2'(e.grant))) begin
      n_fail++;
      $display("FAIL dut%0d cycle %0d: got valid=%b grant=%0d oh=%b, expected valid=%0d grant=%0d oh=%b",
               d, e.cyc, av, ag, aoh, e.valid, e.grant, e.oh);
    end
  endtask

  // monitor: outputs are registered, so every edge presents a result to compare
  always @(posedge clk) begin
    #1;
    if (sb0.size() > 0) check(0, sb0.pop_front());
    if (sb1.size() > 0) check(1, sb1.pop_front());
  end

  initial begin
    set_prt(0, 0, 0, 0);
    repeat (2) cyc(1, 1, 4'b0000, 0);

    // static priorities, aging off vs on
    set_prt(3, 1, 1, 2);
    repeat (12) cyc(0, 1, 4'b1111, 1);
    set_prt(0, 0, 0, 3);
    repeat (30) cyc(0, 1, 4'b1111, 1);

    // single requester: hold, release, one idle cycle, regrant
    cyc(1, 1, 4'b0000, 0);
    repeat (11) cyc(0, 1, 4'b0001, 0);
    cyc(0, 1, 4'b0001, 1);
    repeat (3) cyc(0, 1, 4'b0001, 0);

    // holder 2 drops its request without release
    set_prt(0, 0, 0, 0);
    cyc(1, 1, 4'b0000, 0);
    repeat (2) cyc(0, 1, 4'b0100, 0);
    repeat (3) cyc(0, 1, 4'b1001, 0);

    // clock enable low freezes grant and aging
    set_prt(1, 0, 2, 3);
    repeat (3) cyc(0, 1, 4'b1111, 1);
    repeat (5) cyc(0, 0, 4'b1111, 1);
    repeat (20) cyc(0, 1, 4'b1111, 1);

    // reset mid-hold, with clock enable low, then first grant after reset
    repeat (2) cyc(0, 1, 4'b1111, 0);
    cyc(1, 0, 4'b1111, 0);
    repeat (3) cyc(0, 1, 4'b1111, 0);
    cyc(1, 1, 4'b0000, 0);
    repeat (2) cyc(0, 1, 4'b1010, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0)
        set_prt($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
          4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: entries left %0d/%0d, expected 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dynamic_priority_arbiter_aging.md
# dynamic_priority_arbiter_aging

Registered N-way arbiter with per-requester dynamic priorities, round-robin tie-break within the winning priority level, grant locking until release, and aging so low-priority requesters cannot starve. It sits between requesting masters and a shared resource wherever the plain dynamic-priority round-robin arbiter is too weak. Priority width is decoupled from requester count. Lower priority value means more urgent.

## Interface
- N, 4: number of requesters (≥2).
- LN, $clog2(N): grant index width.
- PW, 2: priority field width, independent of N.
- AGE_TH, 8: wait cycles per one-step priority boost; 0 disables aging.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  cycle enable; when 0 all state, including age counters, holds.
- req  in  N  request vector, level-sensitive.
- prt  in  [PW-1:0] x N (unpacked)  static priority per requester, 0 = most urgent.
- release  in  1  current holder frees the resource.
- grant  out  LN  index of current holder.
- grant_oh  out  N  one-hot of grant, all-zero when valid=0.
- valid  out  1  grant is held.

## Operation
- FSM: IDLE (valid=0) and HOLD (valid=1). Reset enters IDLE; grant=0, grant_oh=0, valid=0, rr_ptr=N-1, all age counters and boosts 0.
- Effective priority: eff[i] = prt[i] > boost[i] ? prt[i]-boost[i] : 0; boost is PW bits, saturating at 2^PW-1.
- Arbitration (combinational): candidates = req bits at minimum eff among requesters; winner = first candidate scanning indices rr_ptr+1, rr_ptr+2, … modulo N.
- IDLE: if clk_en and any req, register winner into grant, valid=1, rr_ptr=winner, go HOLD.
- HOLD: grant frozen while req[grant]=1 and release=0. On release=1, or req[grant]=0, arbitrate in that same cycle with holder's req masked: a winner is registered, otherwise go IDLE (valid=0).
- Aging per requester i, only when clk_en=1: if req[i]=0, clear wait[i] and boost[i]. If i is granted (valid and grant==i), or newly granted at this edge, clear wait[i] and boost[i]. Otherwise wait[i]++; when wait[i] reaches AGE_TH-1, wait[i]=0 and boost[i]++ (saturating). AGE_TH=0: wait/boost stay 0.
- prt changes take effect immediately in arbitration; they never revoke a held grant.

## Timing
- Latency req→valid: 1 cycle (registered outputs).
- Handoff: release in cycle t → new holder visible at edge t+1; no bubble cycle.
- Holder drops req without release: treated as release, same timing.
- release while IDLE: ignored.
- Simultaneous release and new higher-priority req in cycle t: the new req competes at t.
- Single requester repeatedly releasing and re-requesting: masked only for the handoff cycle; if no other requester exists, valid goes 0 for one cycle then regranted.
- clk_en=0 during HOLD: grant held, release ignored.
- rst asserted mid-HOLD: next edge forces reset state regardless of clk_en.
- Wrap-around: rr_ptr=N-1 scans from index 0.
- Boost saturation: a requester with boost ≥ prt competes at eff 0, tied with genuine priority-0 requesters under round-robin.

## Structure
- Package arb_pkg: state enum (IDLE, HOLD), function for saturating subtract, shared with other arbiters.
- Sub-module arb_age_counter (one per requester, generate loop): inputs clk, clk_en, rst, req, granted; output boost[PW-1:0]; parameters AGE_TH, PW.
- Top: eff-priority min tree, rotated first-one select, FSM and registers.

## Test plan
- N=4, PW=2, AGE_TH=0; req=4'b1111, prt={3,1,1,2} (idx3..0), release each cycle → grants 1,2,1,2…; requesters 0 and 3 never granted.
- Same with AGE_TH=4, prt={0,0,0,3}: idx0 granted within ≤ 3×4+N cycles of continuous wait; its boost clears after grant.
- req=4'b0001 from reset → valid=1, grant=0 after 1 cycle; hold 10 cycles with release=0 → grant stable; release → valid=0 next edge, then regrant 0.
- Holder 2 drops req without release while req=4'b1001 equal prt → next edge grant=3, no bubble.
- clk_en=0 for 5 cycles while release=1 → no change; age counters frozen (idx waiting grant timing shifted by exactly 5).
- rst pulsed during HOLD → next edge valid=0, grant=0, grant_oh=0; first post-reset grant picks lowest-index candidate (rr_ptr=N-1).
